// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared constants for the UART transmitter: FSM state
//                encodings, parity mode codes and the parity helper.
//  Contents    : uart_state_t, c_ST_* state codes, c_PAR_* parity modes,
//                parity_bit() helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // FSM state register type and encodings
    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Parity mode codes used by the PARITY parameter
    localparam int c_PAR_NONE = 0;
    localparam int c_PAR_ODD  = 1;
    localparam int c_PAR_EVEN = 2;

    // Parity bit for up to 9 data bits. Narrower words are zero-extended by
    // the caller; the extra zeros do not change the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic w_xor;
        w_xor = ^data;
        return (mode == c_PAR_ODD) ? ~w_xor : w_xor;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_tx_param_if
//  Description : Host-side write interface of the UART transmitter.
//  Signals     : tx_trig  - one-cycle write strobe (host -> UART)
//                tx_data  - word to queue, sampled with tx_trig
//                tx_full  - transmit FIFO is full (UART -> host)
//                tx_ovf   - one-cycle pulse, a push was dropped
//  Modports    : master (host side), slave (UART side)
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_param_if #(
    parameter int DATA_W = 8
) ();

    logic              tx_trig;
    logic [DATA_W-1:0] tx_data;
    logic              tx_full;
    logic              tx_ovf;

    modport master (
        output tx_trig,
        output tx_data,
        input  tx_full,
        input  tx_ovf
    );

    modport slave (
        input  tx_trig,
        input  tx_data,
        output tx_full,
        output tx_ovf
    );

endinterface : uart_tx_param_if
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous first-word-fall-through FIFO feeding the UART
//                transmitter. Pushes into a full FIFO are dropped and
//                flagged with a one-cycle overflow pulse.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                i_push     - write strobe
//                i_wr_data  - write data
//                i_pop      - read strobe (ignored when empty)
//                o_rd_data  - head-of-queue word
//                o_full     - FIFO_DEPTH entries held
//                o_empty    - no entries held
//                o_ovf      - registered pulse: push was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic              i_pop,
    output logic      [DATA_W-1:0] o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_ovf
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;

    logic w_wr;
    logic w_rd;

    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);

    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even while the transmitter is taking a word out.
    assign w_wr = i_push & ~o_full;
    assign w_rd = i_pop  & ~o_empty;

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_ovf     = r_ovf;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_push & o_full;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parameterised UART transmitter with a transmit FIFO.
//                Frame: start(0), DATA_W data bits LSB first, optional
//                parity bit, STOP_BITS stop bits(1); each bit CLK_DIV clocks.
//  Ports       : sclk      - system clock, rising edge
//                srst      - asynchronous active-low reset
//                host      - uart_tx_param_if.slave (tx_trig, tx_data,
//                            tx_full, tx_ovf)
//                rs232_tx  - registered serial line, idle high
//                tx_en     - high while a frame is on the line
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 5208,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic      sclk,
    input  wire logic      srst,
    uart_tx_param_if.slave host,
    output logic           rs232_tx,
    output logic           tx_en
);

    localparam int c_BIT_MAX  = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int c_BITCNT_W = $clog2(c_BIT_MAX);
    localparam int c_DIV_W    = $clog2(CLK_DIV);

    localparam logic [c_DIV_W-1:0]    c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BITCNT_W-1:0] c_DATA_LAST = c_BITCNT_W'(DATA_W - 1);
    localparam logic [c_BITCNT_W-1:0] c_STOP_LAST = c_BITCNT_W'(STOP_BITS - 1);
    localparam bit                    c_HAS_PAR   = (PARITY != c_PAR_NONE);

    // ------------------------------------------------------------------
    // Reset release synchroniser: assertion is immediate, release reaches
    // the FSM two clocks later so it never leaves IDLE on a metastable edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_run;

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_ovf;
    logic              w_pop;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sclk),
        .rst_n     (srst),
        .i_push    (host.tx_trig),
        .i_wr_data (host.tx_data),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_ovf     (w_fifo_ovf)
    );

    assign host.tx_full = w_fifo_full;
    assign host.tx_ovf  = w_fifo_ovf;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    uart_state_t             r_state;
    logic [c_DIV_W-1:0]      r_div;
    logic [c_BITCNT_W-1:0]   r_bitcnt;
    logic [DATA_W-1:0]       r_shift;
    logic                    r_par;
    logic                    r_tx;
    logic                    r_tx_en;

    logic w_bit_end;
    logic w_stop_done;
    logic w_line;

    assign w_bit_end   = (r_div == c_DIV_LAST);
    assign w_stop_done = (r_state == c_ST_STOP) && w_bit_end && (r_bitcnt == c_STOP_LAST);

    // A word is taken either from IDLE or exactly at the end of the last
    // stop bit, which gives back-to-back frames with no idle gap.
    assign w_pop = w_run && !w_fifo_empty &&
                   ((r_state == c_ST_IDLE) || w_stop_done);

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            r_state  <= c_ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
        end else if (w_pop) begin
            r_state  <= c_ST_START;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shift  <= w_fifo_data;
            r_par    <= parity_bit(9'(w_fifo_data), PARITY);
        end else begin
            case (r_state)
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_DATA;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bitcnt == c_DATA_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= c_HAS_PAR ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        if (r_bitcnt == c_STOP_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    // IDLE, and recovery from any unused encoding
                    r_state  <= c_ST_IDLE;
                    r_div    <= '0;
                    r_bitcnt <= '0;
                end
            endcase
        end
    end

    // Line level implied by the current state; registered below so the
    // serial output is glitch-free and lags the FSM by one clock.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_ST_START:  w_line = 1'b0;
            c_ST_DATA:   w_line = r_shift[0];
            c_ST_PARITY: w_line = r_par;
            default:     w_line = 1'b1;
        endcase
    end

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            r_tx    <= 1'b1;
            r_tx_en <= 1'b0;
        end else begin
            r_tx    <= w_line;
            r_tx_en <= (r_state != c_ST_IDLE);
        end
    end

    assign rs232_tx = r_tx;
    assign tx_en    = r_tx_en;

endmodule : uart_tx_param
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Directed self-checking bench for uart_tx_param. Four
//                instances (no parity, even, odd, two stop bits) share clock
//                and reset; CLK_DIV=4, DATA_W=8, FIFO_DEPTH=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int c_DIV = 4;

    logic sclk = 1'b0;
    logic srst = 1'b0;

    always #5 sclk = ~sclk;

    uart_tx_param_if #(.DATA_W(8)) if_a ();
    uart_tx_param_if #(.DATA_W(8)) if_b ();
    uart_tx_param_if #(.DATA_W(8)) if_c ();
    uart_tx_param_if #(.DATA_W(8)) if_d ();

    logic tx_a, tx_b, tx_c, tx_d;
    logic en_a, en_b, en_c, en_d;

    uart_tx_param #(.DATA_W(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .sclk(sclk), .srst(srst), .host(if_a), .rs232_tx(tx_a), .tx_en(en_a));
    uart_tx_param #(.DATA_W(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .sclk(sclk), .srst(srst), .host(if_b), .rs232_tx(tx_b), .tx_en(en_b));
    uart_tx_param #(.DATA_W(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .sclk(sclk), .srst(srst), .host(if_c), .rs232_tx(tx_c), .tx_en(en_c));
    uart_tx_param #(.DATA_W(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .sclk(sclk), .srst(srst), .host(if_d), .rs232_tx(tx_d), .tx_en(en_d));

    int   sel = 0;
    logic line_m, en_m, full_m, ovf_m;

    always_comb begin
        line_m = 1'b0;
        en_m   = 1'b0;
        full_m = 1'b0;
        ovf_m  = 1'b0;
        case (sel)
            0: begin line_m = tx_a; en_m = en_a; full_m = if_a.tx_full; ovf_m = if_a.tx_ovf; end
            1: begin line_m = tx_b; en_m = en_b; full_m = if_b.tx_full; ovf_m = if_b.tx_ovf; end
            2: begin line_m = tx_c; en_m = en_c; full_m = if_c.tx_full; ovf_m = if_c.tx_ovf; end
            default: begin line_m = tx_d; en_m = en_d; full_m = if_d.tx_full; ovf_m = if_d.tx_ovf; end
        endcase
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic set_sel(input int s);
        sel = s;
        #1;
    endtask

    task automatic drive(input int s, input logic trig, input logic [7:0] data);
        case (s)
            0: begin if_a.tx_trig = trig; if_a.tx_data = data; end
            1: begin if_b.tx_trig = trig; if_b.tx_data = data; end
            2: begin if_c.tx_trig = trig; if_c.tx_data = data; end
            default: begin if_d.tx_trig = trig; if_d.tx_data = data; end
        endcase
    endtask

    // Entered on the first sample of the start bit; bit b of 'bits' is the
    // b-th bit placed on the line.
    task automatic check_frame(input string tag, input logic [63:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < c_DIV; c++) begin
                chk($sformatf("%s bit%0d", tag, b), 32'(line_m), 32'(bits[b]));
                chk($sformatf("%s tx_en", tag), 32'(en_m), 32'd1);
                @(negedge sclk);
            end
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s line", tag), 32'(line_m), 32'd1);
            chk($sformatf("%s tx_en", tag), 32'(en_m), 32'd0);
            @(negedge sclk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] fr;

        for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00);
        srst = 1'b0;
        tick(3);

        // Reset state of every instance
        for (int s = 0; s < 4; s++) begin
            set_sel(s);
            chk($sformatf("rst%0d line", s), 32'(line_m), 32'd1);
            chk($sformatf("rst%0d tx_en", s), 32'(en_m), 32'd0);
            chk($sformatf("rst%0d full", s), 32'(full_m), 32'd0);
            chk($sformatf("rst%0d ovf", s), 32'(ovf_m), 32'd0);
        end
        tick(1);
        srst = 1'b1;
        tick(4);

        // No parity, 0x55: latency k+2 then 0101010101
        set_sel(0);
        drive(0, 1'b1, 8'h55);
        tick(1);
        drive(0, 1'b0, 8'h00);
        chk("a55 k line", 32'(line_m), 32'd1);
        tick(1);
        chk("a55 k+1 line", 32'(line_m), 32'd1);
        chk("a55 k+1 tx_en", 32'(en_m), 32'd0);
        tick(1);
        check_frame("a55", 64'h2AA, 10);
        chk("a55 end tx_en", 32'(en_m), 32'd0);
        chk("a55 end line", 32'(line_m), 32'd1);

        // Even parity, 0xFF: parity bit 0, 44 cycles
        set_sel(1);
        drive(1, 1'b1, 8'hFF);
        tick(1);
        drive(1, 1'b0, 8'h00);
        tick(2);
        check_frame("bFF even", 64'h5FE, 11);
        chk("bFF end tx_en", 32'(en_m), 32'd0);

        // Odd parity, 0xAA: parity bit 1
        set_sel(2);
        drive(2, 1'b1, 8'hAA);
        tick(1);
        drive(2, 1'b0, 8'h00);
        tick(2);
        check_frame("cAA odd", 64'h754, 11);
        chk("cAA end tx_en", 32'(en_m), 32'd0);

        // Two stop bits, 0x55 then 0xAA back to back: 88 cycles, no gap
        set_sel(3);
        drive(3, 1'b1, 8'h55);
        tick(1);
        drive(3, 1'b1, 8'hAA);
        tick(1);
        drive(3, 1'b0, 8'h00);
        chk("d k+1 tx_en", 32'(en_m), 32'd0);
        tick(1);
        fr = 64'h754;
        fr = (fr << 11) | 64'h6AA;
        check_frame("d 55/AA", fr, 22);
        chk("d end tx_en", 32'(en_m), 32'd0);
        chk("d end line", 32'(line_m), 32'd1);

        // Six pushes into depth-4 FIFO: 5 accepted, 6th dropped
        set_sel(0);
        drive(0, 1'b1, 8'h01);
        tick(1);
        drive(0, 1'b1, 8'h02);
        tick(1);
        drive(0, 1'b1, 8'h03);
        chk("ovf k+1 tx_en", 32'(en_m), 32'd0);
        tick(1);
        drive(0, 1'b1, 8'h04);
        chk("ovf k+2 tx_en", 32'(en_m), 32'd1);
        chk("ovf k+2 line", 32'(line_m), 32'd0);
        tick(1);
        drive(0, 1'b1, 8'h05);
        chk("ovf 3 queued full", 32'(full_m), 32'd0);
        tick(1);
        drive(0, 1'b1, 8'h06);
        chk("ovf 4 queued full", 32'(full_m), 32'd1);
        chk("ovf before drop", 32'(ovf_m), 32'd0);
        tick(1);
        drive(0, 1'b0, 8'h00);
        chk("ovf pulse", 32'(ovf_m), 32'd1);
        chk("ovf full held", 32'(full_m), 32'd1);
        tick(1);
        chk("ovf pulse end", 32'(ovf_m), 32'd0);
        tick(34);
        chk("full before pop", 32'(full_m), 32'd1);
        tick(1);
        chk("full after pop", 32'(full_m), 32'd0);
        chk("ovf quiet", 32'(ovf_m), 32'd0);
        tick(81);
        fr = 64'h20A;
        fr = (fr << 10) | 64'h208;
        check_frame("q 04/05", fr, 20);
        check_idle("q no 6th", 50);

        // Reset in data bit 3 of 0x55 with 0x33 queued behind it
        drive(0, 1'b1, 8'h55);
        tick(1);
        drive(0, 1'b1, 8'h33);
        tick(1);
        drive(0, 1'b0, 8'h00);
        tick(18);
        chk("rst mid line", 32'(line_m), 32'd0);
        chk("rst mid tx_en", 32'(en_m), 32'd1);
        #2;
        srst = 1'b0;
        #1;
        chk("rst async line", 32'(line_m), 32'd1);
        chk("rst async tx_en", 32'(en_m), 32'd0);
        chk("rst async full", 32'(full_m), 32'd0);
        tick(2);
        srst = 1'b1;
        check_idle("post rst", 60);
        drive(0, 1'b1, 8'hFF);
        tick(1);
        drive(0, 1'b0, 8'h00);
        tick(2);
        check_frame("aFF clean", 64'h3FE, 10);
        chk("aFF end tx_en", 32'(en_m), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_tx_param
`default_nettype wire
